// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM states and channel indices for the cache-to-RAM arbiter.
package mem_arbiter_pkg;
  localparam int MemAddrWidth = 32;
  localparam int MemDataWidth = 32;
  localparam int ChD = 0;
  localparam int ChI = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and RAM-side bus bundle; slave = arbiter, master = caches plus RAM.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int ADDR_W = MemAddrWidth,
  parameter int DATA_W = MemDataWidth
);
  logic [2*NCH-1:0] mem_rwe_i;
  logic [NCH*ADDR_W-1:0] mem_addr_i;
  logic [4*NCH-1:0] mem_sel_i;
  logic [NCH*DATA_W-1:0] mem_data_i;
  logic [NCH*DATA_W-1:0] mem_data_o;
  logic [NCH-1:0] mem_busy_o;
  logic [NCH-1:0] mem_done_o;
  logic ram_req_o;
  logic [3:0] ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;
  logic ram_ack_i;
  modport slave (
    input mem_rwe_i, mem_addr_i, mem_sel_i, mem_data_i, ram_rdata_i, ram_ack_i,
    output mem_data_o, mem_busy_o, mem_done_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
  modport master (
    output mem_rwe_i, mem_addr_i, mem_sel_i, mem_data_i, ram_rdata_i, ram_ack_i,
    input mem_data_o, mem_busy_o, mem_done_o, ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: two-way one-hot grant; ptr = 1 gives ch1 priority, ptr = 0 gives ch0 priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb gnt = (req[ChI] && (ptr || !req[ChD])) ? 2'b10 : req[ChD] ? 2'b01 : 2'b00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between D-cache (ch0) and I-cache (ch1).
// Define ARB_ROUND_ROBIN_EN for two-way round-robin; otherwise ch0 has fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int ADDR_W = MemAddrWidth,
  parameter int DATA_W = MemDataWidth
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_e state_q, state_d;
  logic [NCH-1:0] req, gnt, done;
  logic take, cap, ptr;
  logic win_q, win_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NCH*DATA_W-1:0] rdata_q, rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  assign ptr = ptr_q;
  assign ptr_d = take ? ~gnt[ChI] : ptr_q;
`else
  assign ptr = 1'b0;
`endif
  assign req = {|bus.mem_rwe_i[2*ChI+1:2*ChI], |bus.mem_rwe_i[2*ChD+1:2*ChD]};
  arb_pick u_pick (.req(req), .ptr(ptr), .gnt(gnt));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      sel_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      sel_q <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end
  always_comb begin
    state_d = (state_q == IDLE && |req) ? ISSUE :
              (state_q == ISSUE && bus.ram_ack_i) ? RESP :
              (state_q == RESP) ? IDLE : state_q;
  end
  // Winner's request is latched once in IDLE and held until the RESP cycle.
  always_comb begin
    take = state_q == IDLE && |req;
    cap = state_q == ISSUE && bus.ram_ack_i && !wr_q;
    win_d = take ? gnt[ChI] : win_q;
    wr_d = take ? bus.mem_rwe_i[gnt[ChI] ? 2*ChI+1 : 2*ChD+1] : wr_q;
    addr_d = take ? (gnt[ChI] ? bus.mem_addr_i[2*ADDR_W-1 -: ADDR_W] : bus.mem_addr_i[ADDR_W-1:0]) : addr_q;
    sel_d = take ? (gnt[ChI] ? bus.mem_sel_i[7:4] : bus.mem_sel_i[3:0]) : sel_q;
    wdata_d = take ? (gnt[ChI] ? bus.mem_data_i[2*DATA_W-1 -: DATA_W] : bus.mem_data_i[DATA_W-1:0]) : wdata_q;
    rdata_d[2*DATA_W-1 -: DATA_W] = (cap && win_q) ? bus.ram_rdata_i : rdata_q[2*DATA_W-1 -: DATA_W];
    rdata_d[DATA_W-1:0] = (cap && !win_q) ? bus.ram_rdata_i : rdata_q[DATA_W-1:0];
  end
  always_comb begin
    done = (state_q == RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    bus.ram_req_o = state_q == ISSUE;
    bus.ram_we_o = (state_q == ISSUE && wr_q) ? sel_q : 4'b0000;
    bus.ram_addr_o = addr_q;
    bus.ram_wdata_o = wdata_q;
    bus.mem_data_o = rdata_q;
    bus.mem_done_o = done;
    bus.mem_busy_o = req & ~done;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, corner-case sequences and a random cache/RAM traffic run.
module tb_mem_arbiter;
  typedef struct {
    int ch;
    logic [1:0] rwe;
    logic [31:0] addr;
    logic [3:0] sel;
    logic [31:0] data;
    int dly;
    logic [3:0] exp_we;
    logic [31:0] exp_rd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_ack = 1'b0;
  int cnt = 0;
  int dly = 0;
  int acc = 0;
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] ram [0:255];
  logic [31:0] mdl [0:255];
  logic [31:0] exp_rd [2];
  int mptr;
  always #5 clk = ~clk;
  mem_arbiter_if #(.NCH(2), .ADDR_W(32), .DATA_W(32)) bus();
  mem_arbiter #(.NCH(2), .ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [31:0] init_word(int i);
    return 32'hC0DE0000 | 32'(i);
  endfunction
  assign bus.ram_ack_i = (bus.ram_req_o && cnt == dly) || force_ack;
  assign bus.ram_rdata_i = ram[bus.ram_addr_o[9:2]];
  always @(posedge clk) begin
    cnt <= (bus.ram_req_o && !bus.ram_ack_i) ? cnt + 1 : 0;
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (bus.ram_req_o && bus.ram_ack_i) begin
      acc <= acc + 1;
      for (int b = 0; b < 4; b++)
        if (bus.ram_we_o[b]) ram[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
    end
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic int pick(logic [1:0] r, int p);
    if (r[0] && r[1]) return p;
    return r[1] ? 1 : 0;
  endfunction
  task automatic reset_all();
    @(negedge clk);
    rst = 1'b1;
    force_ack = 1'b0;
    bus.mem_rwe_i = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mdl[i] = init_word(i);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    mptr = 0;
  endtask
  task automatic drive(int ch, logic [1:0] rwe, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    bus.mem_rwe_i[2*ch +: 2] = rwe;
    bus.mem_addr_i[32*ch +: 32] = a;
    bus.mem_sel_i[4*ch +: 4] = s;
    bus.mem_data_i[32*ch +: 32] = d;
  endtask
  task automatic run_vec(vec_t v);
    int reqs = 0;
    int done_k = -1;
    @(negedge clk);
    dly = v.dly;
    bus.mem_rwe_i = '0;
    drive(v.ch, v.rwe, v.addr, v.sel, v.data);
    for (int k = 1; k <= 20 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("lat_req", 64'(bus.ram_req_o), 64'd1);
      if (bus.ram_req_o) begin
        reqs++;
        chk("ram_addr", 64'(bus.ram_addr_o), 64'(v.addr));
        chk("ram_we", 64'(bus.ram_we_o), 64'(v.exp_we));
        chk("ram_wdata", 64'(bus.ram_wdata_o), 64'(v.data));
      end
      if (|bus.mem_done_o) begin
        done_k = k;
        chk("done_vec", 64'(bus.mem_done_o), 64'(2'b01 << v.ch));
      end
    end
    chk("done_lat", 64'(done_k), 64'(v.dly + 2));
    chk("req_cycles", 64'(reqs), 64'(v.dly + 1));
    bus.mem_rwe_i = '0;
    if (v.rwe == 2'b01) exp_rd[v.ch] = v.exp_rd;
    @(negedge clk);
    chk("done_pulse", 64'(bus.mem_done_o), 64'd0);
    chk("data_o", 64'(bus.mem_data_o), {exp_rd[1], exp_rd[0]});
  endtask
  initial begin
    vec_t vt[10];
    int order[$];
    int need0, need1, dn, a0;
    logic [1:0] act, req_drv, exp_done, pend_done, rwe_t[2];
    logic [31:0] addr_t[2], data_t[2];
    logic [3:0] sel_t[2];
    int gap[2], done_n[2];
    int cur_win;
    logic prev_req;
    vt[0] = '{1, 2'b10, 32'h100, 4'hF, 32'hDEADBEEF, 0, 4'hF, 32'h0};
    vt[1] = '{0, 2'b01, 32'h100, 4'hF, 32'h0, 0, 4'h0, 32'hDEADBEEF};
    vt[2] = '{0, 2'b11, 32'h104, 4'h3, 32'h12345678, 1, 4'h3, 32'h0};
    vt[3] = '{1, 2'b01, 32'h104, 4'hF, 32'h11111111, 2, 4'h0, 32'hC0DE5678};
    vt[4] = '{1, 2'b10, 32'h100, 4'h8, 32'hAA000000, 0, 4'h8, 32'h0};
    vt[5] = '{0, 2'b01, 32'h100, 4'hF, 32'h0, 0, 4'h0, 32'hAAADBEEF};
    vt[6] = '{1, 2'b10, 32'h200, 4'h3, 32'h12345678, 5, 4'h3, 32'h0};
    vt[7] = '{1, 2'b01, 32'h108, 4'h0, 32'h0, 3, 4'h0, 32'hC0DE0042};
    vt[8] = '{0, 2'b01, 32'h3FC, 4'hF, 32'h5, 0, 4'h0, 32'hC0DE00FF};
    vt[9] = '{1, 2'b01, 32'h200, 4'hF, 32'h0, 1, 4'h0, 32'hC0DE5678};
    bus.mem_rwe_i = '0;
    bus.mem_addr_i = '0;
    bus.mem_sel_i = '0;
    bus.mem_data_i = '0;
    reset_all();
    chk("rst_req", 64'(bus.ram_req_o), 64'd0);
    chk("rst_we", 64'(bus.ram_we_o), 64'd0);
    chk("rst_addr", 64'(bus.ram_addr_o), 64'd0);
    chk("rst_wdata", 64'(bus.ram_wdata_o), 64'd0);
    chk("rst_done", 64'(bus.mem_done_o), 64'd0);
    chk("rst_busy", 64'(bus.mem_busy_o), 64'd0);
    chk("rst_data", 64'(bus.mem_data_o), 64'd0);
    foreach (vt[i]) run_vec(vt[i]);
    // Simultaneous requests; ch0 wants two accesses, ch1 one.
    reset_all();
    @(negedge clk);
    dly = 0;
    drive(0, 2'b01, 32'h100, 4'hF, 32'h0);
    drive(1, 2'b01, 32'h108, 4'hF, 32'h0);
    need0 = 2;
    need1 = 1;
    for (int k = 0; k < 40 && (need0 > 0 || need1 > 0); k++) begin
      @(negedge clk);
      if (bus.mem_done_o[0]) begin
        order.push_back(0);
        need0--;
        if (need0 == 0) bus.mem_rwe_i[1:0] = 2'b00;
      end
      if (bus.mem_done_o[1]) begin
        order.push_back(1);
        need1--;
        if (need1 == 0) bus.mem_rwe_i[3:2] = 2'b00;
      end
    end
    bus.mem_rwe_i = '0;
    chk("both_count", 64'(order.size()), 64'd3);
    if (order.size() == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("both_order", {32'(order[0]), 16'(order[1]), 16'(order[2])}, {32'd0, 16'd1, 16'd0});
`else
      chk("both_order", {32'(order[0]), 16'(order[1]), 16'(order[2])}, {32'd0, 16'd0, 16'd1});
`endif
    end
    @(negedge clk);
    chk("both_data", 64'(bus.mem_data_o), {32'hC0DE0042, 32'hC0DE0040});
    // Reset while a slow RAM access is in flight, then a stray ack.
    reset_all();
    @(negedge clk);
    dly = 3;
    drive(0, 2'b01, 32'h10C, 4'hF, 32'h0);
    @(negedge clk);
    chk("rsti_req1", 64'(bus.ram_req_o), 64'd1);
    @(negedge clk);
    chk("rsti_req2", 64'(bus.ram_req_o), 64'd1);
    rst = 1'b1;
    bus.mem_rwe_i = '0;
    @(negedge clk);
    chk("rsti_idle", {60'(bus.ram_req_o), 4'(bus.ram_we_o)}, 64'd0);
    chk("rsti_done", 64'(bus.mem_done_o), 64'd0);
    chk("rsti_data", 64'(bus.mem_data_o), 64'd0);
    rst = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      chk("late_ack_req", 64'(bus.ram_req_o), 64'd0);
      dn += int'(|bus.mem_done_o);
      @(negedge clk);
    end
    chk("late_ack_done", 64'(dn), 64'd0);
    // Read held two cycles past its done.
    reset_all();
    @(negedge clk);
    dly = 0;
    a0 = acc;
    dn = 0;
    drive(0, 2'b01, 32'h110, 4'hF, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      dn += int'(bus.mem_done_o[0]);
      if (k == 1) chk("hold_busy_issue", 64'(bus.mem_busy_o[0]), 64'd1);
      if (k == 2) chk("hold_busy_resp", {63'd0, bus.mem_busy_o[0]}, 64'd0);
      if (k == 2) chk("hold_done", 64'(bus.mem_done_o), 64'd1);
      if (k == 4) bus.mem_rwe_i = '0;
    end
    chk("hold_accesses", 64'(acc - a0), 64'd2);
    chk("hold_dones", 64'(dn), 64'd2);
    // Random traffic against a transaction-level model.
    reset_all();
    act = '0;
    req_drv = '0;
    pend_done = '0;
    prev_req = 1'b0;
    cur_win = 0;
    for (int c = 0; c < 2; c++) begin
      gap[c] = 0;
      done_n[c] = 0;
      rwe_t[c] = '0;
      addr_t[c] = '0;
      sel_t[c] = '0;
      data_t[c] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      exp_done = pend_done;
      pend_done = '0;
      chk("rnd_done", 64'(bus.mem_done_o), 64'(exp_done));
      if (bus.ram_req_o && !prev_req) begin
        cur_win = pick(req_drv, mptr);
`ifdef ARB_ROUND_ROBIN_EN
        mptr = 1 - cur_win;
`endif
        chk("rnd_addr", 64'(bus.ram_addr_o), 64'(addr_t[cur_win]));
        chk("rnd_we", 64'(bus.ram_we_o), 64'(rwe_t[cur_win][1] ? sel_t[cur_win] : 4'h0));
        chk("rnd_wdata", 64'(bus.ram_wdata_o), 64'(data_t[cur_win]));
      end
      if (bus.ram_req_o && bus.ram_ack_i) pend_done = 2'b01 << cur_win;
      prev_req = bus.ram_req_o;
      for (int c = 0; c < 2; c++) if (exp_done[c]) begin
        done_n[c]++;
        if (rwe_t[c][1]) begin
          for (int b = 0; b < 4; b++)
            if (sel_t[c][b]) mdl[addr_t[c][9:2]][8*b +: 8] = data_t[c][8*b +: 8];
        end else exp_rd[c] = mdl[addr_t[c][9:2]];
      end
      chk("rnd_data", 64'(bus.mem_data_o), {exp_rd[1], exp_rd[0]});
      chk("rnd_busy", 64'(bus.mem_busy_o), 64'(req_drv & ~exp_done));
      for (int c = 0; c < 2; c++) begin
        if (act[c] && exp_done[c]) begin
          act[c] = 1'b0;
          gap[c] = $urandom_range(0, 2);
        end
        if (!act[c]) begin
          if (gap[c] == 0) begin
            act[c] = 1'b1;
            rwe_t[c] = 2'($urandom_range(1, 3));
            addr_t[c] = 32'($urandom_range(0, 63)) << 2;
            sel_t[c] = 4'($urandom_range(1, 15));
            data_t[c] = $urandom;
          end else gap[c]--;
        end
        drive(c, act[c] ? rwe_t[c] : 2'b00, addr_t[c], sel_t[c], data_t[c]);
      end
      req_drv = act;
      if (!bus.ram_req_o) dly = $urandom_range(0, 3);
    end
    chk("rnd_progress", 64'(done_n[0] > 20 && done_n[1] > 20), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
